// File: rtl/bin2bcd_pkg.sv
// ---------------------------------------------------------------------------
// bin2bcd_pkg
// Shared definitions for the sequential binary-to-BCD converter:
//   state_e      - converter FSM states (2-bit)
//   BCD_DIGIT_W  - width of one BCD digit
//   digits_for() - decimal digits needed to represent a width-bit unsigned value
// ---------------------------------------------------------------------------
package bin2bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // ceil(width * log10(2)) using a fixed-point log10(2) ~= 0.30103
    function automatic int digits_for(input int width);
        return (width * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// ---------------------------------------------------------------------------
// bcd_add3
// Combinational double-dabble digit correction: digits of 5 or more get +3
// so that the following left shift carries correctly into the next digit.
//   digit_i  in   BCD_DIGIT_W  digit before correction
//   digit_o  out  BCD_DIGIT_W  corrected digit
// ---------------------------------------------------------------------------
module bcd_add3
    import bin2bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);

    assign digit_o = (digit_i >= BCD_DIGIT_W'(5)) ? digit_i + BCD_DIGIT_W'(3) : digit_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Sequential shift-and-add-3 binary-to-BCD converter. Watches a level-valid
// binary value and converts it each time a new value appears; the packed BCD
// output only changes in a single cycle, so downstream digit-scan logic never
// sees a partially converted word.
//   clk          in   clock
//   rst          in   asynchronous active-high reset
//   bin_i        in   DATA_WIDTH  unsigned binary value
//   valid_i      in   level-valid for bin_i
//   bcd_o        out  4*DIGITS    packed BCD, digit 0 in bits [3:0]
//   bcd_valid_o  out  sticky: at least one conversion completed
//   done_o       out  one-cycle pulse when bcd_o updates
//   busy_o       out  conversion in progress
//   overflow_o   out  last value did not fit in DIGITS digits
//
// ALLOW_TRUNC acknowledges an intentionally narrow DIGITS (truncated result
// with overflow_o) and silences the elaboration warning.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a valid value different from the last one
// SHIFT | one add-3 + shift iteration per cycle, DATA_WIDTH cycles
// DONE  | publish scratch BCD part, overflow and done pulse
// ---------------------------------------------------------------------------
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int DATA_WIDTH  = 10,
    parameter int DIGITS      = 4,
    parameter bit ALLOW_TRUNC = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         bin_i,
    input  logic                          valid_i,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_o,
    output logic                          bcd_valid_o,
    output logic                          done_o,
    output logic                          busy_o,
    output logic                          overflow_o
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int SCR_W = BCD_W + DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    if (!ALLOW_TRUNC && (DIGITS < digits_for(DATA_WIDTH))) begin : g_digits_chk
        $warning("bin2bcd_seq: DIGITS too small for DATA_WIDTH, results will be truncated");
    end

    state_e                  state_q;
    logic [SCR_W-1:0]        scratch_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    ovf_q;
    logic [DATA_WIDTH-1:0]   last_bin_q;
    logic                    have_last_q;
    logic [BCD_W-1:0]        bcd_q;
    logic                    bcd_valid_q;
    logic                    done_q;
    logic                    overflow_q;

    logic [BCD_W-1:0]        digits_adj;
    logic [SCR_W-1:0]        scratch_adj;
    logic [SCR_W-1:0]        scratch_d;
    logic                    start;

    for (genvar k = 0; k < DIGITS; k++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_i (scratch_q[DATA_WIDTH + BCD_DIGIT_W*k +: BCD_DIGIT_W]),
            .digit_o (digits_adj[BCD_DIGIT_W*k +: BCD_DIGIT_W])
        );
    end

    assign scratch_adj = {digits_adj, scratch_q[DATA_WIDTH-1:0]};
    assign scratch_d   = {scratch_adj[SCR_W-2:0], 1'b0};

    assign start = valid_i && (!have_last_q || (bin_i != last_bin_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            scratch_q   <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            last_bin_q  <= '0;
            have_last_q <= 1'b0;
            bcd_q       <= '0;
            bcd_valid_q <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        scratch_q   <= {{BCD_W{1'b0}}, bin_i};
                        last_bin_q  <= bin_i;
                        have_last_q <= 1'b1;
                        cnt_q       <= '0;
                        ovf_q       <= 1'b0;
                        state_q     <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch_q <= scratch_d;
                    // a 1 leaving the top digit means the value needs more digits
                    ovf_q     <= ovf_q | scratch_adj[SCR_W-1];
                    cnt_q     <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    bcd_q       <= scratch_q[SCR_W-1 -: BCD_W];
                    overflow_q  <= ovf_q;
                    bcd_valid_q <= 1'b1;
                    done_q      <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bcd_o       = bcd_q;
    assign bcd_valid_o = bcd_valid_q;
    assign done_o      = done_q;
    assign busy_o      = (state_q != IDLE);
    assign overflow_o  = overflow_q;

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter that consumes the quotient stream from the unsigned-divider interface stage. It watches the divider's result/valid pair, starts a shift-and-add-3 (double-dabble) conversion whenever a new valid value appears, and presents a stable, tear-free packed BCD word to the display/digit-scan logic.

## Interface
- DATA_WIDTH, 10: width of the binary input; matches the divider stage's DATA_WIDTH.
- DIGITS, 4: number of BCD digits produced; 4 covers 0..1023.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- bin_i  in  DATA_WIDTH  unsigned binary value, connected to the divider `result`.
- valid_i  in  1  level-valid for bin_i, connected to the divider `valid_o` (sticky once high).
- bcd_o  out  4*DIGITS  packed BCD; digit k is bits [4k+3:4k], with digit 0 the least significant.
- bcd_valid_o  out  1  high once the first conversion has completed; sticky until reset.
- done_o  out  1  one-cycle pulse when bcd_o updates.
- busy_o  out  1  high while a conversion is in progress.
- overflow_o  out  1  high when the last converted value exceeded 10^DIGITS-1.

## Operation
- Reset values: bcd_o=0, bcd_valid_o=0, done_o=0, busy_o=0, overflow_o=0, FSM=IDLE, last_bin=0, have_last=0.
- Start condition, evaluated only in IDLE: valid_i && (!have_last || bin_i != last_bin).
- States:
  - IDLE: if the start condition holds:
    - load scratch = {DIGITS*4 zeros, bin_i};
    - set last_bin = bin_i and have_last = 1;
    - clear cnt and the ovf accumulator;
    - go to SHIFT.
  - SHIFT: each cycle:
    - apply add-3 to every BCD digit >= 5;
    - shift the whole scratch left by 1;
    - OR the bit shifted out of the top digit into ovf;
    - cnt++. After DATA_WIDTH iterations, go to DONE.
  - DONE:
    - bcd_o = BCD part of scratch;
    - overflow_o = ovf;
    - bcd_valid_o = 1;
    - done_o = 1;
    - go to IDLE.
- busy_o = (state != IDLE).
- bin_i and valid_i are ignored outside IDLE. A value that changes mid-conversion is picked up in the first IDLE cycle because it differs from last_bin.
- An unchanged bin_i with valid_i held high does not retrigger a conversion.
- valid_i falling has no effect on any output. bcd_o keeps its last value.
- bcd_o changes only in DONE, never during SHIFT.
- On overflow, bcd_o holds the low DIGITS digits of the true result (truncated); no saturation.
- cnt width is $clog2(DATA_WIDTH+1). The scratch register width is DIGITS*4+DATA_WIDTH.

## Timing
- Start accepted at edge N. SHIFT iterations occur on edges N+1..N+DATA_WIDTH. DONE occurs at edge N+DATA_WIDTH+1.
- bcd_o and done_o are visible after edge N+DATA_WIDTH+1, giving a latency of DATA_WIDTH+1 cycles (11 at default).
- busy_o is high from after edge N until after edge N+DATA_WIDTH+1 (DATA_WIDTH+1 cycles).
- Minimum start-to-start spacing is DATA_WIDTH+2 cycles, because one IDLE cycle is required between conversions.
- Reset asserted mid-conversion aborts immediately: all outputs and state return to reset values, and no done_o is issued.
- After reset release, a still-high valid_i restarts conversion on the first edge (have_last=0).

## Structure
- Shared package bin2bcd_pkg:
  - state enum IDLE/SHIFT/DONE (2-bit);
  - BCD_DIGIT_W=4;
  - function digits_for(width) returning ceil(width*log10(2)), used for DIGITS sanity checks.
- Sub-module bcd_add3: combinational 4-bit digit correction (d>=5 ? d+3 : d). It is instantiated DIGITS times via generate.
- Elaboration check: a warning if DIGITS < digits_for(DATA_WIDTH).

## Test plan
- Reset, then valid_i=1 and bin_i=0 → after 11 cycles done_o pulses; bcd_o=0x0000, bcd_valid_o=1, overflow_o=0.
- bin_i=1023 → bcd_o=0x1023 exactly 11 cycles after the start edge; busy_o high for 11 cycles.
- bin_i held at 999 with valid_i high for 50 cycles → exactly one done_o pulse; bcd_o=0x0999.
- Start a conversion of 500, then change bin_i to 42 at SHIFT iteration 3:
  - bcd_o=0x0500 first;
  - one IDLE cycle;
  - second conversion yields 0x0042.
- DIGITS=3 with bin_i=1023 → overflow_o=1, bcd_o=0x023. A following value of 7 gives overflow_o=0, bcd_o=0x007.
- Assert rst during SHIFT of 777 → all outputs 0 on the same cycle, no done_o. Release rst with valid_i=1 and 777 still on bin_i → reconverts to 0x0777.
